// File: rtl/pwm_fade_controller.sv
// pwm_fade_controller: accepts a target duty cycle over valid/ready and ramps
// the registered duty toward it by C_STEP every C_TICK_DIV enabled cycles.
// Drives var_pwm_module's duty and enable, forcing a true 0% output at duty 0.
`timescale 1ns/1ps
module pwm_fade_controller #(
  parameter int C_RES      = 8,
  parameter int C_TICK_DIV = 1000,
  parameter int C_STEP     = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [C_RES-1:0] i_target,
  input  logic             i_target_valid,
  output logic             o_target_ready,
  input  logic             i_en,
  output logic [C_RES-1:0] o_duty_cycle,
  output logic             o_pwm_en,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RAMP_UP   = 2'd1;
  localparam logic [1:0] S_RAMP_DOWN = 2'd2;

  localparam logic [15:0]      TICK_LAST = 16'(C_TICK_DIV - 1);
  localparam logic [C_RES:0]   STEP_X    = (C_RES+1)'(C_STEP);
  localparam logic [C_RES-1:0] STEP_N    = C_RES'(C_STEP);

  logic [1:0]       state_q, state_d;
  logic [15:0]      presc_q, presc_d;
  logic [C_RES-1:0] target_q, target_d;
  logic [C_RES-1:0] duty_q, duty_d;
  logic             done_q, done_d;

  // Upward step, saturating at the target so the duty never wraps.
  function automatic logic [C_RES-1:0] step_up(input logic [C_RES-1:0] duty,
                                               input logic [C_RES-1:0] tgt);
    logic [C_RES:0] sum;
    sum = {1'b0, duty} + STEP_X;
    if (sum >= {1'b0, tgt}) step_up = tgt;
    else                    step_up = sum[C_RES-1:0];
  endfunction

  // Downward step, landing exactly on the target when within one step.
  function automatic logic [C_RES-1:0] step_down(input logic [C_RES-1:0] duty,
                                                 input logic [C_RES-1:0] tgt);
    logic [C_RES:0] diff;
    diff = {1'b0, duty} - {1'b0, tgt};
    if (diff <= STEP_X) step_down = tgt;
    else                step_down = duty - STEP_N;
  endfunction

  // Next-state logic: handshake in IDLE, prescaled stepping in the ramp states.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    target_d = target_q;
    duty_d   = duty_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_target_valid) begin
          target_d = i_target;
          presc_d  = '0;
          if (i_target > duty_q)      state_d = S_RAMP_UP;
          else if (i_target < duty_q) state_d = S_RAMP_DOWN;
          else                        done_d  = 1'b1;
        end
      end
      S_RAMP_UP, S_RAMP_DOWN: begin
        if (i_en) begin
          if (presc_q == TICK_LAST) begin
            presc_d = '0;
            if (state_q == S_RAMP_UP) duty_d = step_up(duty_q, target_q);
            else                      duty_d = step_down(duty_q, target_q);
            if (duty_d == target_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      target_q <= '0;
      duty_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      target_q <= target_d;
      duty_q   <= duty_d;
      done_q   <= done_d;
    end
  end

  assign o_duty_cycle   = duty_q;
  assign o_done         = done_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_target_ready = (state_q == S_IDLE);
  // Gate the PWM off at duty 0, since the PWM core clamps 0 up to 1.
  assign o_pwm_en       = i_en && (duty_q != '0);

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Testbench for pwm_fade_controller: scenario tasks checked against an
// arithmetic model of the ramp (steps taken = enabled cycles / tick divider).
`timescale 1ns/1ps
module tb_pwm_fade_controller;
  localparam int RES  = 8;
  localparam int TICK = 4;
  localparam int STEP = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [RES-1:0] tgt = '0;
  logic           vld = 1'b0;
  logic           en = 1'b1;
  logic           ready;
  logic [RES-1:0] duty;
  logic           pwm_en;
  logic           busy;
  logic           done;

  int total = 0;
  int bad = 0;
  int model_duty = 0;

  pwm_fade_controller #(.C_RES(RES), .C_TICK_DIV(TICK), .C_STEP(STEP)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_target(tgt),
    .i_target_valid(vld),
    .o_target_ready(ready),
    .i_en(en),
    .o_duty_cycle(duty),
    .o_pwm_en(pwm_en),
    .o_busy(busy),
    .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_xfer(input int t);
    tgt = 8'(t);
    vld = 1'b1;
    @(posedge clk);
    #1;
    vld = 1'b0;
  endtask

  // Number of paused (i_en low) edges among edges 1..c after the transfer.
  function automatic int paused_upto(input int c, input int ps, input int plen);
    if (plen == 0 || c <= ps) return 0;
    if (c - ps > plen) return plen;
    return c - ps;
  endfunction

  // Transfer target t from the current model duty and check every cycle until
  // the ramp settles. ps/plen: i_en low for edges ps+1..ps+plen.
  // spam: 0 none, 1 request 200 while busy, 2 random requests while busy.
  task automatic drive_and_check_ramp(input string name, input int t, input int ps,
                                      input int plen, input int spam);
    int start, span, nsteps, act, act_prev, s, exp_duty;
    bit exp_busy, exp_done, exp_pen;
    start  = model_duty;
    span   = (t > start) ? t - start : start - t;
    nsteps = (span + STEP - 1) / STEP;
    do_xfer(t);
    for (int c = 0; c <= nsteps * TICK + plen + 1; c++) begin
      if (c > 0) tick();
      act      = c - paused_upto(c, ps, plen);
      act_prev = (c > 0) ? (c - 1) - paused_upto(c - 1, ps, plen) : 0;
      s = act / TICK;
      if (s > nsteps) s = nsteps;
      if (t > start) exp_duty = (start + s * STEP > t) ? t : start + s * STEP;
      else           exp_duty = (start - s * STEP < t) ? t : start - s * STEP;
      exp_busy = (act < nsteps * TICK);
      if (c == 0) exp_done = (nsteps == 0);
      else        exp_done = (nsteps > 0) && (act == nsteps * TICK) && (act_prev < nsteps * TICK);
      exp_pen = en && (exp_duty != 0);
      total++;
      if (duty !== 8'(exp_duty)) begin
        bad++;
        $display("FAIL %s duty c=%0d got=%0d exp=%0d", name, c, duty, exp_duty);
      end
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL %s busy c=%0d got=%0b exp=%0b", name, c, busy, exp_busy);
      end
      total++;
      if (ready !== !exp_busy) begin
        bad++;
        $display("FAIL %s ready c=%0d got=%0b exp=%0b", name, c, ready, !exp_busy);
      end
      total++;
      if (done !== exp_done) begin
        bad++;
        $display("FAIL %s done c=%0d got=%0b exp=%0b", name, c, done, exp_done);
      end
      total++;
      if (pwm_en !== exp_pen) begin
        bad++;
        $display("FAIL %s pwm_en c=%0d got=%0b exp=%0b", name, c, pwm_en, exp_pen);
      end
      if (plen > 0 && c == ps) en = 1'b0;
      if (plen > 0 && c == ps + plen) en = 1'b1;
      vld = (spam != 0) && exp_busy;
      if (vld) tgt = (spam == 1) ? 8'd200 : 8'($urandom_range(0, 255));
    end
    vld = 1'b0;
    en = 1'b1;
    model_duty = t;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (duty !== 8'd0 || pwm_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_outputs got duty=%0d pen=%0b busy=%0b done=%0b rdy=%0b exp 0/0/0/0/1",
               duty, pwm_en, busy, done, ready);
    end
    tick();
    tick();
    total++;
    if (duty !== 8'd0 || busy !== 1'b0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold got duty=%0d busy=%0b rdy=%0b exp 0/0/1", duty, busy, ready);
    end
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    model_duty = 0;
  endtask

  task automatic test_ramp_up();
    drive_and_check_ramp("ramp_up_50", 50, 0, 0, 0);
  endtask

  task automatic test_ramp_down_sat();
    drive_and_check_ramp("ramp_down_0", 0, 0, 0, 0);
    drive_and_check_ramp("ramp_up_250", 250, 0, 0, 0);
    drive_and_check_ramp("sat_255", 255, 0, 0, 0);
  endtask

  task automatic test_equal_and_busy();
    drive_and_check_ramp("down_to_50", 50, 0, 0, 0);
    drive_and_check_ramp("equal_50", 50, 0, 0, 0);
    drive_and_check_ramp("busy_req_200", 120, 0, 0, 1);
  endtask

  task automatic test_enable_pause();
    drive_and_check_ramp("pause", 170, 2, 6, 0);
  endtask

  task automatic test_reset_mid_ramp();
    drive_and_check_ramp("back_to_0", 0, 0, 0, 0);
    do_xfer(200);
    for (int i = 0; i < 2 * TICK; i++) tick();
    total++;
    if (duty !== 8'd32) begin
      bad++;
      $display("FAIL pre_reset_duty got=%0d exp=32", duty);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (duty !== 8'd0 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0 || pwm_en !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got duty=%0d busy=%0b rdy=%0b done=%0b pen=%0b exp 0/0/1/0/0",
               duty, busy, ready, done, pwm_en);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (done !== 1'b0 || duty !== 8'd0) begin
        bad++;
        $display("FAIL reset_no_done got done=%0b duty=%0d exp 0/0", done, duty);
      end
    end
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    model_duty = 0;
  endtask

  task automatic test_random();
    int t, span, nsteps, ps, plen, spam;
    for (int i = 0; i < 15; i++) begin
      t = int'($urandom_range(0, 255));
      span = (t > model_duty) ? t - model_duty : model_duty - t;
      nsteps = (span + STEP - 1) / STEP;
      plen = 0;
      ps = 0;
      if ($urandom_range(0, 2) == 0) begin
        ps = int'($urandom_range(0, nsteps * TICK));
        plen = int'($urandom_range(1, 8));
      end
      spam = (nsteps > 0 && $urandom_range(0, 1) == 1) ? 2 : 0;
      drive_and_check_ramp("random", t, ps, plen, spam);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down_sat();
    test_equal_and_busy();
    test_enable_pause();
    test_reset_mid_ramp();
    test_ramp_up();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
